// File: rtl/branch_predictor_pkg.sv
// Shared types, mode constants and PC field helpers for the fetch-stage branch predictor.
package branch_predictor_pkg;

   localparam int BP_MODE_BIMODAL = 0;
   localparam int BP_MODE_GSHARE  = 1;

   function automatic logic [31:0] idx_of(input logic [31:0] pc, input int index_bits);
      return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
   endfunction

   // A zero tag width yields an all-zero tag, so every valid entry matches.
   function automatic logic [31:0] tag_of(input logic [31:0] pc, input int index_bits,
                                          input int tag_width);
      return (pc >> (index_bits + 2)) & ((32'd1 << tag_width) - 32'd1);
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute <-> predictor signal bundle: lookup request, prediction and training update.
interface branch_predictor_if #(
   parameter int HISTORY_WIDTH = 4
) ();
   logic                     lookup_valid;
   logic [31:0]              lookup_pc;
   logic                     predict_valid;
   logic                     predict_taken;
   logic [31:0]              predict_target;
   logic [HISTORY_WIDTH-1:0] predict_history;
   logic                     update_valid;
   logic [31:0]              update_pc;
   logic                     update_taken;
   logic [31:0]              update_target;
   logic [HISTORY_WIDTH-1:0] update_history;

   modport master (
      output lookup_valid, lookup_pc,
      output update_valid, update_pc, update_taken, update_target, update_history,
      input  predict_valid, predict_taken, predict_target, predict_history
   );

   modport slave (
      input  lookup_valid, lookup_pc,
      input  update_valid, update_pc, update_taken, update_target, update_history,
      output predict_valid, predict_taken, predict_target, predict_history
   );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Combinational saturating up/down counter step with weak-taken / weak-not-taken initialisation.
module branch_predictor_sat_counter #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] value,
   input  logic             inc,
   input  logic             dec,
   input  logic             init,
   input  logic             init_taken,
   output logic [WIDTH-1:0] next_value
);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] MAX     = '1;
   localparam logic [WIDTH-1:0] WEAK_T  = ONE << (WIDTH - 1);
   localparam logic [WIDTH-1:0] WEAK_NT = WEAK_T - ONE;

   always_comb begin
      next_value = value;
      if (init) begin
         next_value = init_taken ? WEAK_T : WEAK_NT;
      end else if (inc && (value != MAX)) begin
         next_value = value + ONE;
      end else if (dec && (value != '0)) begin
         next_value = value - ONE;
      end
   end
endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: tagged BTB plus saturating direction counters,
// bimodal or gshare indexed, one-cycle registered prediction, trained by execute.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES       = 64,
   parameter int TAG_WIDTH     = 10,
   parameter int COUNTER_WIDTH = 2,
   parameter int MODE          = 0,
   parameter int HISTORY_WIDTH = 4
) (
   input logic               clk,
   input logic               rst,
   branch_predictor_if.slave bp
);
   localparam int INDEX_BITS = $clog2(ENTRIES);
   localparam int TW         = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
   localparam logic [COUNTER_WIDTH-1:0] CTR_WEAK_NT =
      (COUNTER_WIDTH'(1) << (COUNTER_WIDTH - 1)) - COUNTER_WIDTH'(1);

   typedef struct packed {
      logic                     valid;
      logic [TW-1:0]            tag;
      logic [31:0]              target;
      logic [COUNTER_WIDTH-1:0] counter;
   } bp_entry_t;

   bp_entry_t                table_q [ENTRIES];
   logic [HISTORY_WIDTH-1:0] ghr_q;
   logic [HISTORY_WIDTH-1:0] ghr_next;

   logic                     pred_valid_q;
   logic                     pred_taken_q;
   logic [31:0]              pred_target_q;
   logic [HISTORY_WIDTH-1:0] pred_history_q;

   function automatic logic [INDEX_BITS-1:0] index_of(input logic [31:0] pc,
                                                      input logic [HISTORY_WIDTH-1:0] hist);
      logic [INDEX_BITS-1:0] base;
      base = INDEX_BITS'(idx_of(pc, INDEX_BITS));
      if (MODE == BP_MODE_GSHARE) base = base ^ INDEX_BITS'(hist);
      return base;
   endfunction

   function automatic logic [TW-1:0] tag_field(input logic [31:0] pc);
      return TW'(tag_of(pc, INDEX_BITS, TAG_WIDTH));
   endfunction

   function automatic logic entry_hit(input bp_entry_t e, input logic [31:0] pc);
      return e.valid && ((TAG_WIDTH == 0) || (e.tag == tag_field(pc)));
   endfunction

   logic [INDEX_BITS-1:0] look_idx;
   bp_entry_t             look_entry;
   logic                  look_taken;
   logic [31:0]           look_target;

   // The table is sampled at the lookup edge, so a same-cycle update is never seen.
   always_comb begin
      look_idx    = index_of(bp.lookup_pc, ghr_q);
      look_entry  = table_q[look_idx];
      look_taken  = entry_hit(look_entry, bp.lookup_pc) && look_entry.counter[COUNTER_WIDTH-1];
      look_target = look_taken ? look_entry.target : (bp.lookup_pc + 32'd4);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_valid_q   <= 1'b0;
         pred_taken_q   <= 1'b0;
         pred_target_q  <= '0;
         pred_history_q <= '0;
      end else begin
         pred_valid_q <= bp.lookup_valid;
         if (bp.lookup_valid) begin
            pred_taken_q   <= look_taken;
            pred_target_q  <= look_target;
            pred_history_q <= ghr_q;
         end
      end
   end

   logic [INDEX_BITS-1:0]    upd_idx;
   bp_entry_t                upd_entry;
   bp_entry_t                upd_new;
   logic                     upd_hit;
   logic [COUNTER_WIDTH-1:0] upd_ctr_next;

   always_comb begin
      upd_idx   = index_of(bp.update_pc, bp.update_history);
      upd_entry = table_q[upd_idx];
      upd_hit   = entry_hit(upd_entry, bp.update_pc);
   end

   branch_predictor_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_sat_counter (
      .value      (upd_entry.counter),
      .inc        (bp.update_taken),
      .dec        (!bp.update_taken),
      .init       (!upd_hit),
      .init_taken (bp.update_taken),
      .next_value (upd_ctr_next)
   );

   always_comb begin
      upd_new.valid   = 1'b1;
      upd_new.tag     = tag_field(bp.update_pc);
      upd_new.target  = (!upd_hit || bp.update_taken) ? bp.update_target : upd_entry.target;
      upd_new.counter = upd_ctr_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, counter: CTR_WEAK_NT};
         end
      end else if (bp.update_valid) begin
         table_q[upd_idx] <= upd_new;
      end
   end

   generate
      if (HISTORY_WIDTH == 1) begin : g_ghr_one
         assign ghr_next = bp.update_taken;
      end else begin : g_ghr_shift
         assign ghr_next = {ghr_q[HISTORY_WIDTH-2:0], bp.update_taken};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q <= '0;
      end else if (bp.update_valid) begin
         ghr_q <= ghr_next;
      end
   end

   assign bp.predict_valid   = pred_valid_q;
   assign bp.predict_taken   = pred_taken_q;
   assign bp.predict_target  = pred_target_q;
   assign bp.predict_history = pred_history_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: bimodal vector table plus gshare and async-reset sequences.
module tb_branch_predictor;
   import branch_predictor_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_predictor_if #(.HISTORY_WIDTH(4)) bif ();
   branch_predictor_if #(.HISTORY_WIDTH(4)) gif ();

   branch_predictor #(
      .ENTRIES(64), .TAG_WIDTH(10), .COUNTER_WIDTH(2),
      .MODE(BP_MODE_BIMODAL), .HISTORY_WIDTH(4)
   ) dut_b (.clk(clk), .rst(rst), .bp(bif));

   branch_predictor #(
      .ENTRIES(64), .TAG_WIDTH(10), .COUNTER_WIDTH(2),
      .MODE(BP_MODE_GSHARE), .HISTORY_WIDTH(4)
   ) dut_g (.clk(clk), .rst(rst), .bp(gif));

   typedef struct {
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        lv;
      logic [31:0] lpc;
      logic        ev;
      logic        et;
      logic [31:0] etgt;
   } vec_t;

   localparam int NVEC = 23;
   vec_t vecs [NVEC];

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_b();
      bif.lookup_valid   = 1'b0;
      bif.lookup_pc      = 32'h0;
      bif.update_valid   = 1'b0;
      bif.update_pc      = 32'h0;
      bif.update_taken   = 1'b0;
      bif.update_target  = 32'h0;
      bif.update_history = 4'h0;
   endtask

   task automatic drive_g(input logic uv, input logic [31:0] upc, input logic ut,
                          input logic [31:0] utgt, input logic [3:0] uh,
                          input logic lv, input logic [31:0] lpc);
      gif.update_valid   = uv;
      gif.update_pc      = upc;
      gif.update_taken   = ut;
      gif.update_target  = utgt;
      gif.update_history = uh;
      gif.lookup_valid   = lv;
      gif.lookup_pc      = lpc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            uv    upc           ut    utgt          lv    lpc           ev    et    etgt
      vecs[0]  = '{1'b0, 32'h0,       1'b0, 32'h0,     1'b1, 32'h100,   1'b1, 1'b0, 32'h104};
      vecs[1]  = '{1'b1, 32'h100,     1'b1, 32'h200,   1'b0, 32'h0,     1'b0, 1'b0, 32'h104};
      vecs[2]  = '{1'b0, 32'h0,       1'b0, 32'h0,     1'b1, 32'h100,   1'b1, 1'b1, 32'h200};
      vecs[3]  = '{1'b0, 32'h0,       1'b0, 32'h0,     1'b1, 32'h10100, 1'b1, 1'b0, 32'h10104};
      vecs[4]  = '{1'b1, 32'h100,     1'b1, 32'h200,   1'b0, 32'h0,     1'b0, 1'b0, 32'h10104};
      vecs[5]  = '{1'b1, 32'h100,     1'b1, 32'h200,   1'b0, 32'h0,     1'b0, 1'b0, 32'h10104};
      vecs[6]  = '{1'b1, 32'h100,     1'b0, 32'h300,   1'b1, 32'h100,   1'b1, 1'b1, 32'h200};
      vecs[7]  = '{1'b1, 32'h100,     1'b0, 32'h300,   1'b1, 32'h100,   1'b1, 1'b1, 32'h200};
      vecs[8]  = '{1'b0, 32'h0,       1'b0, 32'h0,     1'b1, 32'h100,   1'b1, 1'b0, 32'h104};
      vecs[9]  = '{1'b1, 32'h180,     1'b1, 32'h400,   1'b1, 32'h180,   1'b1, 1'b0, 32'h184};
      vecs[10] = '{1'b0, 32'h0,       1'b0, 32'h0,     1'b1, 32'h180,   1'b1, 1'b1, 32'h400};
      vecs[11] = '{1'b1, 32'h184,     1'b0, 32'h999,   1'b1, 32'h184,   1'b1, 1'b0, 32'h188};
      vecs[12] = '{1'b0, 32'h0,       1'b0, 32'h0,     1'b1, 32'h184,   1'b1, 1'b0, 32'h188};
      vecs[13] = '{1'b1, 32'h184,     1'b1, 32'h500,   1'b0, 32'h0,     1'b0, 1'b0, 32'h188};
      vecs[14] = '{1'b0, 32'h0,       1'b0, 32'h0,     1'b1, 32'h184,   1'b1, 1'b1, 32'h500};
      vecs[15] = '{1'b1, 32'h184,     1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 32'h500};
      vecs[16] = '{1'b1, 32'h184,     1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 32'h500};
      vecs[17] = '{1'b1, 32'h184,     1'b0, 32'h0,     1'b0, 32'h0,     1'b0, 1'b1, 32'h500};
      vecs[18] = '{1'b0, 32'h0,       1'b0, 32'h0,     1'b1, 32'h184,   1'b1, 1'b0, 32'h188};
      vecs[19] = '{1'b1, 32'h184,     1'b1, 32'h500,   1'b0, 32'h0,     1'b0, 1'b0, 32'h188};
      vecs[20] = '{1'b0, 32'h0,       1'b0, 32'h0,     1'b1, 32'h184,   1'b1, 1'b0, 32'h188};
      vecs[21] = '{1'b1, 32'h184,     1'b1, 32'h500,   1'b0, 32'h0,     1'b0, 1'b0, 32'h188};
      vecs[22] = '{1'b0, 32'h0,       1'b0, 32'h0,     1'b1, 32'h184,   1'b1, 1'b1, 32'h500};

      idle_b();
      gif.lookup_valid   = 1'b0;
      gif.lookup_pc      = 32'h0;
      gif.update_valid   = 1'b0;
      gif.update_pc      = 32'h0;
      gif.update_taken   = 1'b0;
      gif.update_target  = 32'h0;
      gif.update_history = 4'h0;

      rst = 1'b1;
      #3;
      check("rst b valid",   32'(bif.predict_valid),   32'h0);
      check("rst b taken",   32'(bif.predict_taken),   32'h0);
      check("rst b target",  bif.predict_target,       32'h0);
      check("rst b history", 32'(bif.predict_history), 32'h0);
      check("rst g valid",   32'(gif.predict_valid),   32'h0);
      check("rst g history", 32'(gif.predict_history), 32'h0);
      #9;
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         bif.update_valid  = vecs[i].uv;
         bif.update_pc     = vecs[i].upc;
         bif.update_taken  = vecs[i].ut;
         bif.update_target = vecs[i].utgt;
         bif.lookup_valid  = vecs[i].lv;
         bif.lookup_pc     = vecs[i].lpc;
         @(posedge clk);
         #1;
         check($sformatf("v%0d valid", i),  32'(bif.predict_valid), 32'(vecs[i].ev));
         check($sformatf("v%0d taken", i),  32'(bif.predict_taken), 32'(vecs[i].et));
         check($sformatf("v%0d target", i), bif.predict_target,     vecs[i].etgt);
      end
      idle_b();

      // gshare: history T,T,N -> 0110, then an update carrying history 6 trains entry 6.
      drive_g(1'b1, 32'h7C0, 1'b1, 32'h900, 4'h0, 1'b0, 32'h0);
      drive_g(1'b1, 32'h7C0, 1'b1, 32'h900, 4'h0, 1'b0, 32'h0);
      drive_g(1'b1, 32'h7C0, 1'b0, 32'h900, 4'h0, 1'b0, 32'h0);
      drive_g(1'b0, 32'h0,   1'b0, 32'h0,   4'h0, 1'b1, 32'h100);
      check("g hist after TTN", 32'(gif.predict_history), 32'h6);
      check("g lookup valid",   32'(gif.predict_valid),   32'h1);
      check("g lookup taken",   32'(gif.predict_taken),   32'h0);
      check("g lookup target",  gif.predict_target,       32'h104);
      drive_g(1'b1, 32'h100, 1'b1, 32'h200, 4'h6, 1'b0, 32'h0);
      // GHR is now 1101: pc 0x12C maps to entry 6, pc 0x134 maps to entry 0, both tag 1.
      drive_g(1'b0, 32'h0,   1'b0, 32'h0,   4'h0, 1'b1, 32'h12C);
      check("g entry6 history", 32'(gif.predict_history), 32'hD);
      check("g entry6 taken",   32'(gif.predict_taken),   32'h1);
      check("g entry6 target",  gif.predict_target,       32'h200);
      drive_g(1'b0, 32'h0,   1'b0, 32'h0,   4'h0, 1'b1, 32'h134);
      check("g entry0 taken",   32'(gif.predict_taken),   32'h0);
      check("g entry0 target",  gif.predict_target,       32'h138);
      drive_g(1'b0, 32'h0,   1'b0, 32'h0,   4'h0, 1'b0, 32'h0);

      // Asynchronous reset between the lookup edge and the following edge.
      bif.lookup_valid = 1'b1;
      bif.lookup_pc    = 32'h180;
      @(posedge clk);
      #1;
      check("pre-rst valid",  32'(bif.predict_valid), 32'h1);
      check("pre-rst taken",  32'(bif.predict_taken), 32'h1);
      check("pre-rst target", bif.predict_target,     32'h400);
      bif.lookup_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("async rst valid",   32'(bif.predict_valid),   32'h0);
      check("async rst taken",   32'(bif.predict_taken),   32'h0);
      check("async rst target",  bif.predict_target,       32'h0);
      check("async rst history", 32'(bif.predict_history), 32'h0);
      #1;
      rst = 1'b0;
      bif.lookup_valid = 1'b1;
      bif.lookup_pc    = 32'h180;
      @(posedge clk);
      #1;
      check("post-rst valid",  32'(bif.predict_valid), 32'h1);
      check("post-rst taken",  32'(bif.predict_taken), 32'h0);
      check("post-rst target", bif.predict_target,     32'h184);
      idle_b();
      @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
